// File: rtl/fb_arbiter.sv
// fb_arbiter: shares a single-port frame buffer RAM between the VGA display
// reader and the camera capture writer. Display reads always win; camera
// writes wait in a small FIFO and drain in the slots the display leaves free.
// The 320x240 buffer is shown 2x upscaled on a 640x480 raster.
//
// Ports
//   gobal_clk, reset         pixel clock, synchronous active-high reset
//   vga_row/col/valid        raster position from the timing generator
//   pix_out, pix_valid       pixel for the position sampled two edges earlier
//   cam_wr_en/addr/data      camera write request, accepted when cam_ready
//   cam_ready                write queue not full (combinational)
//   mem_addr/we/wdata        registered RAM request
//   mem_rdata                RAM read data, one cycle after the request
//   err_drop                 sticky: write offered while full or out of range
module fb_arbiter #(
  parameter int unsigned FB_W     = 320,
  parameter int unsigned FB_H     = 240,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic              gobal_clk,
  input  logic              reset,
  input  logic [9:0]        vga_row,
  input  logic [9:0]        vga_col,
  input  logic              vga_valid,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  input  logic              cam_wr_en,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_drop
);

  localparam int unsigned PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  // Write queue storage and bookkeeping
  logic [ADDR_W-1:0] r_q_addr [WQ_DEPTH];
  logic [DATA_W-1:0] r_q_data [WQ_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Read pipeline: stage 0 = request issued, stage 1 = RAM output valid
  logic r_vv0, r_vv1;
  logic r_rd0, r_rd1;

  slot_e             w_slot;
  logic              w_full;
  logic              w_in_range;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_unused_row;

  // Row LSB is dropped by the 2x vertical upscale
  assign w_unused_row = vga_row[0];

  assign w_full     = (r_count == CNT_W'(WQ_DEPTH));
  assign cam_ready  = !w_full;
  assign w_in_range = ({1'b0, cam_addr} < FB_SIZE);
  assign w_push     = cam_wr_en && !w_full && w_in_range;
  assign w_drop     = cam_wr_en && (w_full || !w_in_range);
  assign w_pop      = (w_slot == SLOT_WRITE);

  // Buffer address for the current raster position (2x upscale)
  assign w_rd_addr = ADDR_W'(vga_row[9:1]) * ADDR_W'(FB_W) + ADDR_W'(vga_col[9:1]);

  // Slot grant: even visible columns read, otherwise drain the queue
  always_comb begin
    w_slot = SLOT_IDLE;
    if (vga_valid && !vga_col[0]) begin
      w_slot = SLOT_READ;
    end else if (r_count != '0) begin
      w_slot = SLOT_WRITE;
    end
  end

  // Queue payload; no reset needed, validity is tracked by r_count
  always_ff @(posedge gobal_clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= cam_addr;
      r_q_data[r_wr_ptr] <= cam_data;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge gobal_clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // RAM request register; mem_addr holds through idle slots
  always_ff @(posedge gobal_clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (w_slot)
        SLOT_READ: begin
          mem_addr <= w_rd_addr;
          mem_we   <= 1'b0;
        end
        SLOT_WRITE: begin
          mem_addr  <= r_q_addr[r_rd_ptr];
          mem_wdata <= r_q_data[r_rd_ptr];
          mem_we    <= 1'b1;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  // Sticky drop flag
  always_ff @(posedge gobal_clk) begin
    if (reset) begin
      err_drop <= 1'b0;
    end else if (w_drop) begin
      err_drop <= 1'b1;
    end
  end

  // Display pipeline; odd columns keep the pixel fetched on the even column
  always_ff @(posedge gobal_clk) begin
    if (reset) begin
      r_vv0     <= 1'b0;
      r_vv1     <= 1'b0;
      r_rd0     <= 1'b0;
      r_rd1     <= 1'b0;
      pix_valid <= 1'b0;
      pix_out   <= '0;
    end else begin
      r_vv0     <= vga_valid;
      r_vv1     <= r_vv0;
      r_rd0     <= (w_slot == SLOT_READ);
      r_rd1     <= r_rd0;
      pix_valid <= r_vv1;
      if (!r_vv1) begin
        pix_out <= '0;
      end else if (r_rd1) begin
        pix_out <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  localparam int FBSZ = 320 * 240;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  vga_row, vga_col;
  logic        vga_valid;
  logic [11:0] pix_out;
  logic        pix_valid;
  logic        cam_wr_en;
  logic [16:0] cam_addr;
  logic [11:0] cam_data;
  logic        cam_ready;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        err_drop;

  int n_assert = 0;
  int n_fail   = 0;

  fb_arbiter dut (
    .gobal_clk (clk),
    .reset     (reset),
    .vga_row   (vga_row),
    .vga_col   (vga_col),
    .vga_valid (vga_valid),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .cam_wr_en (cam_wr_en),
    .cam_addr  (cam_addr),
    .cam_data  (cam_data),
    .cam_ready (cam_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, preloaded with addr[11:0] on the first edge
  logic [11:0] ram [0:131071];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 131072; i++) ram[i] <= 12'(i);
      ram_init <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: pending writes as a queue, expected buffer contents,
  // and a 2-deep delay line of expected pixels.
  typedef struct {
    int          addr;
    logic [11:0] data;
  } wr_t;

  wr_t         q[$];
  logic [11:0] exp_ram [0:FBSZ-1];
  bit          m_we, m_err, m_pv;
  int          m_addr;
  logic [11:0] m_wdata, m_px;
  bit          p0v, p1v;
  logic [11:0] p0x, p1x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step(input bit rst, input int r, input int c, input bit we,
                            input int a, input logic [11:0] d);
    bit vis;
    int sz0;
    wr_t e;
    vis = (r < 480) && (c < 640);
    if (rst) begin
      q.delete();
      m_we = 0; m_addr = 0; m_wdata = '0; m_err = 0;
      p0v = 0; p1v = 0; m_pv = 0;
      p0x = '0; p1x = '0; m_px = '0;
    end else begin
      sz0 = q.size();
      m_we = 0;
      if (vis && (c % 2 == 0)) begin
        m_addr = (r / 2) * 320 + c / 2;
      end else if (sz0 > 0) begin
        e = q.pop_front();
        m_we = 1; m_addr = e.addr; m_wdata = e.data;
      end
      if (we) begin
        if (sz0 >= 4 || a >= FBSZ) m_err = 1;
        else begin
          e.addr = a; e.data = d;
          q.push_back(e);
          exp_ram[a] = d;
        end
      end
      m_pv = p1v;
      m_px = p1v ? p1x : 12'h000;
      p1v = p0v; p1x = p0x;
      p0v = vis;
      p0x = vis ? exp_ram[(r / 2) * 320 + c / 2] : 12'h000;
    end
  endtask

  task automatic check_outputs();
    chk("mem_we",    32'(mem_we),    32'(m_we));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("cam_ready", 32'(cam_ready), 32'(q.size() < 4));
    chk("err_drop",  32'(err_drop),  32'(m_err));
    chk("pix_valid", 32'(pix_valid), 32'(m_pv));
    chk("pix_out",   32'(pix_out),   32'(m_px));
  endtask

  task automatic step(input bit rst, input int r, input int c, input bit we,
                      input int a, input logic [11:0] d);
    reset     = rst;
    vga_row   = 10'(r);
    vga_col   = 10'(c);
    vga_valid = (r < 480) && (c < 640);
    cam_wr_en = we;
    cam_addr  = 17'(a);
    cam_data  = d;
    @(posedge clk);
    model_step(rst, r, c, we, a, d);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int r, c, a;
    bit we;
    logic [11:0] d;

    for (int i = 0; i < FBSZ; i++) exp_ram[i] = 12'(i);
    reset = 1'b1; vga_row = '0; vga_col = '0; vga_valid = 1'b0;
    cam_wr_en = 1'b0; cam_addr = '0; cam_data = '0;
    m_we = 0; m_addr = 0; m_wdata = '0; m_err = 0; m_pv = 0; m_px = '0;
    p0v = 0; p1v = 0; p0x = '0; p1x = '0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 12'h0);
    chk("rst_cam_ready", 32'(cam_ready), 32'd1);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);

    // Display only, rows 10 and 11; pixel for (10,7) is buffer (5,3)
    for (int row = 10; row < 12; row++) begin
      for (int col = 0; col < 800; col++) begin
        step(0, row, col, 0, 0, 12'h0);
        if (row == 10 && col == 9) chk("t1_pix_r10c7", 32'(pix_out), 32'h643);
      end
    end

    // Camera writes every 2 cycles through the active part of row 12
    for (int col = 0; col < 800; col++) begin
      we = (col < 640) && (col % 2 == 0);
      step(0, 12, col, we, 100, 12'hABC);
    end
    chk("t2_ram100", 32'(ram[100]), 32'hABC);

    // Burst of 8 back-to-back writes in the active area: the 8th hits full
    for (int col = 0; col < 120; col++) begin
      we = (col >= 20 && col < 28);
      step(0, 14, col, we, 74000 + col - 20, 12'((col - 20) * 12'h111 + 12'h005));
      if (col == 26) chk("t3_ready_low", 32'(cam_ready), 32'd0);
      if (col == 27) chk("t3_err", 32'(err_drop), 32'd1);
    end
    for (int k = 0; k < 7; k++)
      chk("t3_ram_order", 32'(ram[74000 + k]), 32'(12'(k * 12'h111 + 12'h005)));
    chk("t3_dropped_untouched", 32'(ram[74007]), 32'(12'(74007)));

    step(1, 0, 0, 0, 0, 12'h0);
    step(1, 0, 0, 0, 0, 12'h0);

    // Out-of-range address during blanking
    chk("t4_err_before", 32'(err_drop), 32'd0);
    step(0, 500, 100, 1, FBSZ, 12'h123);
    chk("t4_err", 32'(err_drop), 32'd1);
    chk("t4_ready", 32'(cam_ready), 32'd1);
    for (int col = 101; col < 110; col++) step(0, 500, col, 0, 0, 12'h0);

    // Reset mid-line with three writes queued
    for (int col = 0; col < 15; col++) begin
      we = (col >= 10);
      step(0, 20, col, we, 2000 + col, 12'hF0F);
    end
    step(1, 20, 15, 0, 0, 12'h0);
    chk("t5_we", 32'(mem_we), 32'd0);
    chk("t5_ready", 32'(cam_ready), 32'd1);
    step(0, 20, 16, 0, 0, 12'h0);
    chk("t5_pv0", 32'(pix_valid), 32'd0);
    step(0, 20, 17, 0, 0, 12'h0);
    chk("t5_pv1", 32'(pix_valid), 32'd0);
    for (int col = 18; col < 40; col++) step(0, 20, col, 0, 0, 12'h0);

    // End of visible line: last read at column 638
    for (int col = 630; col < 646; col++) begin
      step(0, 479, col, 0, 0, 12'h0);
      if (col == 639 || col == 645) chk("t6_last_read", 32'(mem_addr), 32'd76799);
    end
    // Vertical blanking: a write granted every cycle
    for (int col = 0; col < 12; col++) begin
      step(0, 480, col, 1, 2000 + col, 12'(col + 12'h300));
      if (col >= 1) chk("t6_blank_we", 32'(mem_we), 32'd1);
    end
    // Frame wrap
    for (int col = 790; col < 800; col++) step(0, 524, col, col == 790, 3000, 12'h777);
    step(0, 0, 0, 0, 0, 12'h0);
    chk("t6_wrap_addr", 32'(mem_addr), 32'd0);
    chk("t6_wrap_we", 32'(mem_we), 32'd0);
    for (int col = 1; col < 10; col++) step(0, 0, col, 0, 0, 12'h0);

    // Randomized segments: rows away from the written region
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 1) == 1) r = int'($urandom_range(0, 458));
      else r = int'($urandom_range(480, 523));
      c = 2 * int'($urandom_range(0, 399));
      for (int i = 0; i < 60; i++) begin
        we = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 15) == 0) a = FBSZ + int'($urandom_range(0, 100));
        else a = 73600 + int'($urandom_range(0, 3199));
        d = 12'($urandom);
        step(0, r, c, we, a, d);
        c++;
        if (c > 799) begin c = 0; r = (r + 1) % 525; end
      end
    end
    for (int col = 0; col < 10; col++) step(0, 500, col, 0, 0, 12'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
